noise_table_loader: RTL and testbench

NOISE_TABLE_LOADER -- requirements
Module: noise_table_loader

---
 rtl/noise_pkg.sv | 17 +
 rtl/noise_rd_pipe.sv | 49 ++++
 rtl/noise_table_loader.sv | 174 +++++++++++++++++
 tb/tb_noise_table_loader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noise_pkg.sv
// Shared types for the noise table loader: FSM state encoding, table word and table address.
package noise_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_WAIT_DONE,
        ST_FINISH
    } state_e;

    typedef logic [63:0] word_t;
    typedef logic [7:0]  addr_t;

    localparam int TMO_W = 16;

endpackage

// File: rtl/noise_rd_pipe.sv
// Delay line that carries each read strobe and its address forward by RD_LAT cycles,
// so they line up with the table memory's returned data.
module noise_rd_pipe
    import noise_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic  clk,
    input  logic  rstn,
    input  logic  in_valid,
    input  addr_t in_addr,
    output logic  out_valid,
    output addr_t out_addr
);

    logic  vld_q  [RD_LAT];
    addr_t addr_q [RD_LAT];

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        vld_q[gi]  <= 1'b0;
                        addr_q[gi] <= '0;
                    end else begin
                        vld_q[gi]  <= in_valid;
                        addr_q[gi] <= in_addr;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        vld_q[gi]  <= 1'b0;
                        addr_q[gi] <= '0;
                    end else begin
                        vld_q[gi]  <= vld_q[gi-1];
                        addr_q[gi] <= addr_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign out_valid = vld_q[RD_LAT-1];
    assign out_addr  = addr_q[RD_LAT-1];

endmodule

// File: rtl/noise_table_loader.sv
// Streams a noise table from memory into the noise generator, then waits for its ack.
// Optional build macro NOISE_LOADER_CHECKSUM_EN adds an XOR checksum check against exp_sum.
module noise_table_loader
    import noise_pkg::*;
#(
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [7:0]  num_words,
    output logic        rd_en,
    output logic [7:0]  rd_addr,
    input  logic [63:0] rd_data,
    output logic [63:0] mem_data,
    output logic [7:0]  location,
    output logic        load_mem,
    input  logic        done_wait,
`ifdef NOISE_LOADER_CHECKSUM_EN
    input  logic [63:0] exp_sum,
`endif
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_e            state_q;
    addr_t             num_q;
    addr_t             issue_q;
    addr_t             rd_addr_q;
    logic              rd_en_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [TMO_W-1:0]  tmo_q;
    word_t             mem_hold_q;
    addr_t             loc_hold_q;

    logic              pipe_vld;
    addr_t             pipe_addr;
    logic              accept;
    logic              last_word;
    logic              chk_ok;

    noise_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (rd_en_q),
        .in_addr   (rd_addr_q),
        .out_valid (pipe_vld),
        .out_addr  (pipe_addr)
    );

    assign accept    = (state_q == ST_IDLE) && start && (num_words != 8'd0);
    assign last_word = pipe_vld && (pipe_addr == num_q - 8'd1);

    // Data arrives RD_LAT cycles after the strobe, so it is forwarded straight through
    // on presented cycles and a held copy covers the idle cycles.
    assign load_mem = pipe_vld;
    assign mem_data = pipe_vld ? rd_data   : mem_hold_q;
    assign location = pipe_vld ? pipe_addr : loc_hold_q;

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_hold_q <= '0;
            loc_hold_q <= '0;
        end else if (pipe_vld) begin
            mem_hold_q <= rd_data;
            loc_hold_q <= pipe_addr;
        end
    end

`ifdef NOISE_LOADER_CHECKSUM_EN
    word_t sum_q;
    word_t exp_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_q <= '0;
            exp_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
            exp_q <= exp_sum;
        end else if (pipe_vld) begin
            sum_q <= sum_q ^ rd_data;
        end
    end

    // Only consulted on the last presented word, which is folded in here.
    assign chk_ok = ((sum_q ^ rd_data) == exp_q);
`else
    assign chk_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            num_q     <= '0;
            issue_q   <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        num_q   <= num_words;
                        issue_q <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= issue_q;
                    issue_q   <= issue_q + 8'd1;
                    if (issue_q == num_q - 8'd1) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_word) begin
                        if (chk_ok) begin
                            tmo_q   <= '0;
                            state_q <= ST_WAIT_DONE;
                        end else begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (done_wait) begin
                        done_q  <= 1'b1;
                        state_q <= ST_FINISH;
                    end else if (tmo_q >= TMO_LAST) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (tmo_q != '1) begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noise_table_loader.sv
// Directed bench for noise_table_loader: one DUT at RD_LAT=1 and one at RD_LAT=3, both TIMEOUT=16.
// Cycle k means the interval after the k-th rising edge following the cycle in which start is driven.
module tb_noise_table_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    logic        start_a, rd_en_a, load_a, done_wait_a, busy_a, done_a, err_a;
    logic [7:0]  num_a, rd_addr_a, loc_a;
    logic [63:0] rd_data_a, mem_data_a;
    logic        start_b, rd_en_b, load_b, done_wait_b, busy_b, done_b, err_b;
    logic [7:0]  num_b, rd_addr_b, loc_b;
    logic [63:0] rd_data_b, mem_data_b;
`ifdef NOISE_LOADER_CHECKSUM_EN
    logic [63:0] exp_sum_a, exp_sum_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int data_mode = 0;

    noise_table_loader #(.RD_LAT(1), .TIMEOUT(16)) dut_a (
        .clk(clk), .rstn(rstn), .start(start_a), .num_words(num_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .mem_data(mem_data_a), .location(loc_a), .load_mem(load_a),
        .done_wait(done_wait_a),
`ifdef NOISE_LOADER_CHECKSUM_EN
        .exp_sum(exp_sum_a),
`endif
        .busy(busy_a), .done(done_a), .err(err_a)
    );

    noise_table_loader #(.RD_LAT(3), .TIMEOUT(16)) dut_b (
        .clk(clk), .rstn(rstn), .start(start_b), .num_words(num_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .mem_data(mem_data_b), .location(loc_b), .load_mem(load_b),
        .done_wait(done_wait_b),
`ifdef NOISE_LOADER_CHECKSUM_EN
        .exp_sum(exp_sum_b),
`endif
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    // Table contents: mode 0 = index replicated per nibble, mode 1 = index + 1.
    function automatic logic [63:0] word_of(input logic [7:0] a, input int mode);
        if (mode == 0) return {16{a[3:0]}};
        return 64'(a) + 64'd1;
    endfunction

    // Memory models: data for the address strobed RD_LAT cycles earlier, junk otherwise.
    logic [3:0] mv_a = '0;
    logic [3:0] mv_b = '0;
    logic [7:0] ma_a [4];
    logic [7:0] ma_b [4];
    always @(posedge clk) begin
        mv_a <= {mv_a[2:0], rd_en_a};
        mv_b <= {mv_b[2:0], rd_en_b};
        ma_a[0] <= rd_addr_a;
        ma_b[0] <= rd_addr_b;
        for (int i = 1; i < 4; i++) begin
            ma_a[i] <= ma_a[i-1];
            ma_b[i] <= ma_b[i-1];
        end
    end
    assign rd_data_a = mv_a[0] ? word_of(ma_a[0], data_mode) : 64'hDEAD_BEEF_0BAD_F00D;
    assign rd_data_b = mv_b[2] ? word_of(ma_b[2], data_mode) : 64'hDEAD_BEEF_0BAD_F00D;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        start_a = 1'b0; num_a = 8'd0; done_wait_a = 1'b0;
        start_b = 1'b0; num_b = 8'd0; done_wait_b = 1'b0;
`ifdef NOISE_LOADER_CHECKSUM_EN
        exp_sum_a = '0; exp_sum_b = '0;
`endif
        repeat (3) tick;
        n_cmp++; if (rd_en_a !== 1'b0) begin n_bad++; $display("FAIL reset.rd_en got %b want 0", rd_en_a); end
        n_cmp++; if (rd_addr_a !== 8'd0) begin n_bad++; $display("FAIL reset.rd_addr got %h want 00", rd_addr_a); end
        n_cmp++; if (mem_data_a !== 64'd0) begin n_bad++; $display("FAIL reset.mem_data got %h want 0", mem_data_a); end
        n_cmp++; if (loc_a !== 8'd0) begin n_bad++; $display("FAIL reset.location got %h want 00", loc_a); end
        n_cmp++; if (load_a !== 1'b0) begin n_bad++; $display("FAIL reset.load_mem got %b want 0", load_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset.busy got %b want 0", busy_a); end
        n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset.done got %b want 0", done_a); end
        n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL reset.err got %b want 0", err_a); end
        n_cmp++; if ({load_b, busy_b, rd_en_b} !== 3'b000) begin n_bad++; $display("FAIL reset.dut_b got %b want 000", {load_b, busy_b, rd_en_b}); end
        #3 rstn = 1'b1;
        repeat (2) tick;
        $display("test_reset: outputs checked under reset");
    endtask

    // 15 words at RD_LAT=1; done_wait also pulsed early (incl. the last load cycle) and must be ignored.
    task automatic test_basic;
        logic exp_rd, exp_ld, exp_busy, exp_done;
        logic [7:0] eloc;
        logic [63:0] edat;
        data_mode = 0;
        num_a = 8'd15; start_a = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick;
            start_a = 1'b0;
            done_wait_a = ((k >= 10 && k <= 17) || k == 22);
            exp_rd   = (k >= 2 && k <= 16);
            exp_ld   = (k >= 3 && k <= 17);
            exp_busy = (k >= 1 && k <= 23);
            exp_done = (k == 23);
            eloc = (k < 3) ? 8'd0 : ((k <= 17) ? 8'(k - 3) : 8'd14);
            edat = (k < 3) ? 64'd0 : {16{eloc[3:0]}};
            n_cmp++; if (rd_en_a !== exp_rd) begin n_bad++; $display("FAIL basic.rd_en k=%0d got %b want %b", k, rd_en_a, exp_rd); end
            if (exp_rd) begin
                n_cmp++; if (rd_addr_a !== 8'(k - 2)) begin n_bad++; $display("FAIL basic.rd_addr k=%0d got %0d want %0d", k, rd_addr_a, k - 2); end
            end
            n_cmp++; if (load_a !== exp_ld) begin n_bad++; $display("FAIL basic.load_mem k=%0d got %b want %b", k, load_a, exp_ld); end
            n_cmp++; if (loc_a !== eloc) begin n_bad++; $display("FAIL basic.location k=%0d got %0d want %0d", k, loc_a, eloc); end
            n_cmp++; if (mem_data_a !== edat) begin n_bad++; $display("FAIL basic.mem_data k=%0d got %h want %h", k, mem_data_a, edat); end
            n_cmp++; if (busy_a !== exp_busy) begin n_bad++; $display("FAIL basic.busy k=%0d got %b want %b", k, busy_a, exp_busy); end
            n_cmp++; if (done_a !== exp_done) begin n_bad++; $display("FAIL basic.done k=%0d got %b want %b", k, done_a, exp_done); end
            n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL basic.err k=%0d got %b want 0", k, err_a); end
        end
        done_wait_a = 1'b0;
        $display("test_basic: 15-word load at RD_LAT=1 checked");
    endtask

    task automatic test_rdlat3;
        logic exp_rd, exp_ld, exp_busy, exp_done;
        logic [7:0] eloc;
        data_mode = 0;
        num_b = 8'd4; start_b = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick;
            start_b = 1'b0;
            done_wait_b = (k == 9);
            exp_rd   = (k >= 2 && k <= 5);
            exp_ld   = (k >= 5 && k <= 8);
            exp_busy = (k >= 1 && k <= 10);
            exp_done = (k == 10);
            eloc = 8'(k - 5);
            n_cmp++; if (rd_en_b !== exp_rd) begin n_bad++; $display("FAIL lat3.rd_en k=%0d got %b want %b", k, rd_en_b, exp_rd); end
            n_cmp++; if (load_b !== exp_ld) begin n_bad++; $display("FAIL lat3.load_mem k=%0d got %b want %b", k, load_b, exp_ld); end
            if (exp_ld) begin
                n_cmp++; if (loc_b !== eloc) begin n_bad++; $display("FAIL lat3.location k=%0d got %0d want %0d", k, loc_b, eloc); end
                n_cmp++; if (mem_data_b !== {16{eloc[3:0]}}) begin n_bad++; $display("FAIL lat3.mem_data k=%0d got %h want %h", k, mem_data_b, {16{eloc[3:0]}}); end
            end
            n_cmp++; if (busy_b !== exp_busy) begin n_bad++; $display("FAIL lat3.busy k=%0d got %b want %b", k, busy_b, exp_busy); end
            n_cmp++; if (done_b !== exp_done) begin n_bad++; $display("FAIL lat3.done k=%0d got %b want %b", k, done_b, exp_done); end
        end
        done_wait_b = 1'b0;
        $display("test_rdlat3: 4-word load at RD_LAT=3 checked");
    endtask

    // 2 words: WAIT_DONE entered in cycle 5, so err must rise in cycle 21 with no done.
    task automatic test_timeout;
        logic exp_busy, exp_err;
        num_a = 8'd2; start_a = 1'b1; done_wait_a = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            tick;
            start_a = 1'b0;
            exp_busy = (k >= 1 && k <= 20);
            exp_err  = (k >= 21);
            n_cmp++; if (load_a !== (k >= 3 && k <= 4)) begin n_bad++; $display("FAIL timeout.load_mem k=%0d got %b", k, load_a); end
            n_cmp++; if (busy_a !== exp_busy) begin n_bad++; $display("FAIL timeout.busy k=%0d got %b want %b", k, busy_a, exp_busy); end
            n_cmp++; if (err_a !== exp_err) begin n_bad++; $display("FAIL timeout.err k=%0d got %b want %b", k, err_a, exp_err); end
            n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL timeout.done k=%0d got %b want 0", k, done_a); end
        end
        $display("test_timeout: err after 16 idle WAIT_DONE cycles checked");
    endtask

    // Entered with err=1 from the timeout: a zero-length start must leave it, a real start clears it.
    task automatic test_ignore;
        logic exp_rd, exp_ld, exp_busy;
        num_a = 8'd0; start_a = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick;
            start_a = 1'b0;
            n_cmp++; if ({busy_a, rd_en_a} !== 2'b00) begin n_bad++; $display("FAIL ignore.zero_len k=%0d got %b want 00", k, {busy_a, rd_en_a}); end
            n_cmp++; if (err_a !== 1'b1) begin n_bad++; $display("FAIL ignore.err_kept k=%0d got %b want 1", k, err_a); end
        end
        num_a = 8'd5; start_a = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick;
            start_a = (k == 3);
            if (k == 3) num_a = 8'd9;
            done_wait_a = (k == 8);
            exp_rd   = (k >= 2 && k <= 6);
            exp_ld   = (k >= 3 && k <= 7);
            exp_busy = (k >= 1 && k <= 9);
            n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL ignore.err k=%0d got %b want 0", k, err_a); end
            n_cmp++; if (rd_en_a !== exp_rd) begin n_bad++; $display("FAIL ignore.rd_en k=%0d got %b want %b", k, rd_en_a, exp_rd); end
            if (exp_rd) begin
                n_cmp++; if (rd_addr_a !== 8'(k - 2)) begin n_bad++; $display("FAIL ignore.rd_addr k=%0d got %0d want %0d", k, rd_addr_a, k - 2); end
            end
            n_cmp++; if (load_a !== exp_ld) begin n_bad++; $display("FAIL ignore.load_mem k=%0d got %b want %b", k, load_a, exp_ld); end
            n_cmp++; if (busy_a !== exp_busy) begin n_bad++; $display("FAIL ignore.busy k=%0d got %b want %b", k, busy_a, exp_busy); end
            n_cmp++; if (done_a !== (k == 9)) begin n_bad++; $display("FAIL ignore.done k=%0d got %b", k, done_a); end
        end
        done_wait_a = 1'b0;
        $display("test_ignore: zero-length and busy starts checked");
    endtask

    task automatic test_reset_mid;
        num_a = 8'd15; start_a = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            start_a = 1'b0;
        end
        n_cmp++; if ({load_a, loc_a} !== {1'b1, 8'd7}) begin n_bad++; $display("FAIL midrst.word7 got load=%b loc=%0d want load=1 loc=7", load_a, loc_a); end
        #2 rstn = 1'b0;
        #1;
        n_cmp++; if ({rd_en_a, load_a, busy_a, done_a, err_a} !== 5'b0) begin n_bad++; $display("FAIL midrst.flags got %b want 00000", {rd_en_a, load_a, busy_a, done_a, err_a}); end
        n_cmp++; if ({rd_addr_a, loc_a} !== 16'd0) begin n_bad++; $display("FAIL midrst.addr got rd_addr=%0d loc=%0d want 0", rd_addr_a, loc_a); end
        n_cmp++; if (mem_data_a !== 64'd0) begin n_bad++; $display("FAIL midrst.mem_data got %h want 0", mem_data_a); end
        tick;
        #3 rstn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick;
            n_cmp++; if ({load_a, rd_en_a, busy_a} !== 3'b000) begin n_bad++; $display("FAIL midrst.quiet k=%0d got %b want 000", k, {load_a, rd_en_a, busy_a}); end
        end
        num_a = 8'd3; start_a = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            start_a = 1'b0;
            done_wait_a = (k == 6);
            n_cmp++; if (load_a !== (k >= 3 && k <= 5)) begin n_bad++; $display("FAIL midrst.reload_ld k=%0d got %b", k, load_a); end
            if (k >= 3 && k <= 5) begin
                n_cmp++; if (loc_a !== 8'(k - 3)) begin n_bad++; $display("FAIL midrst.reload_loc k=%0d got %0d want %0d", k, loc_a, k - 3); end
            end
            n_cmp++; if (done_a !== (k == 7)) begin n_bad++; $display("FAIL midrst.reload_done k=%0d got %b", k, done_a); end
        end
        done_wait_a = 1'b0;
        $display("test_reset_mid: abort at word 7 and reload checked");
    endtask

`ifdef NOISE_LOADER_CHECKSUM_EN
    // Words 1,2,3,4 XOR to 4: the first run must finish, the second (expecting 5) must error.
    task automatic test_checksum;
        logic exp_err;
        data_mode = 1;
        num_a = 8'd4; exp_sum_a = 64'h4; start_a = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick;
            start_a = 1'b0;
            done_wait_a = (k == 7);
            if (k >= 3 && k <= 6) begin
                n_cmp++; if (mem_data_a !== 64'(k - 2)) begin n_bad++; $display("FAIL csum.mem_data k=%0d got %h want %h", k, mem_data_a, 64'(k - 2)); end
            end
            n_cmp++; if (done_a !== (k == 8)) begin n_bad++; $display("FAIL csum.good_done k=%0d got %b", k, done_a); end
            n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL csum.good_err k=%0d got %b want 0", k, err_a); end
        end
        exp_sum_a = 64'h5; start_a = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick;
            start_a = 1'b0;
            done_wait_a = 1'b1;
            exp_err = (k >= 7);
            n_cmp++; if (err_a !== exp_err) begin n_bad++; $display("FAIL csum.bad_err k=%0d got %b want %b", k, err_a, exp_err); end
            n_cmp++; if (busy_a !== (k <= 6)) begin n_bad++; $display("FAIL csum.bad_busy k=%0d got %b", k, busy_a); end
            n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL csum.bad_done k=%0d got %b want 0", k, done_a); end
        end
        done_wait_a = 1'b0;
        data_mode = 0;
        $display("test_checksum: matching and mismatching checksums checked");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_rdlat3();
        test_timeout();
        test_ignore();
        test_reset_mid();
`ifdef NOISE_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
